// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM.
// States, opcode constants and datapath mux select codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_ILLEGAL,
    S_BUSERR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // States that hold a request on the shared memory
  function automatic logic is_mem_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) ||
           (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Counts stalled memory cycles and flags a timeout on the
// last allowed cycle unless the memory answers that cycle.
module ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  localparam int W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;
  logic         stall;

  assign stall = waiting && !ready;

  // Wait counter: restarts on every state change
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= cnt + ONE;
    end
  end

  assign timeout = stall && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multi-cycle RV32I subset datapath.
// Optional perf counters: define MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic       bus_err
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  state_t state;
  state_t state_next;
  logic   waiting;
  logic   timeout;
  logic   taken;

  // funct7b5 is decoded by the ALU decoder, not here
  logic unused_f7;
  assign unused_f7 = funct7b5;

  assign waiting = is_mem_wait(state);

  ctrl_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .waiting(waiting),
    .ready  (mem_ready),
    .clear  (state_next != state),
    .timeout(timeout)
  );

  // Branch condition: beq/bne only, other funct3 fall through
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      default: taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; error states hold until reset
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    state_next = S_DECODE;
        else if (timeout) state_next = S_BUSERR;
      end
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_LOAD),
          (opcode == OP_STORE):  state_next = S_MEMADR;
          (opcode == OP_RTYPE):  state_next = S_EXECR;
          (opcode == OP_ITYPE):  state_next = S_EXECI;
          (opcode == OP_BRANCH): state_next = S_BRANCH;
          default:               state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        state_next = (opcode == OP_LOAD) ? S_MEMRD
                                         : S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_ready)    state_next = S_MEMWB;
        else if (timeout) state_next = S_BUSERR;
      end
      S_MEMWR: begin
        if (mem_ready)    state_next = S_FETCH;
        else if (timeout) state_next = S_BUSERR;
      end
      S_MEMWB:  state_next = S_FETCH;
      S_EXECR:  state_next = S_ALUWB;
      S_EXECI:  state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      default:  state_next = state;
    endcase
  end

  // Output decode; everything is held low during reset
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (opcode == OP_LOAD) ? IMM_I
                                          : IMM_S;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = RES_MEM;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALU_FUNCT;
        end
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_I;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          result_src = RES_ALUOUT;
        end
        S_BRANCH: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op     = ALU_SUB;
          result_src = RES_ALUOUT;
          pc_write   = taken;
        end
        S_ILLEGAL: illegal = 1'b1;
        S_BUSERR:  bus_err = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic halted;
  logic retire;

  assign halted = (state == S_ILLEGAL) ||
                  (state == S_BUSERR);
  assign retire = (state_next == S_FETCH) &&
                  ((state == S_MEMWB) ||
                   (state == S_MEMWR) ||
                   (state == S_ALUWB) ||
                   (state == S_BRANCH));

  // Cycle and retired-instruction counters, frozen on error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (!halted) begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (retire) instret_cnt <= instret_cnt + CNT_ONE;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction
// timeline model predicts every cycle of control outputs.
module tb_multicycle_ctrl;

  localparam int T = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       illegal;
  logic       bus_err;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  multicycle_ctrl #(
    .TIMEOUT_CYCLES(T),
    .CNT_W(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_write (mem_write),
    .adr_src   (adr_src),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .imm_src   (imm_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .result_src(result_src),
    .illegal   (illegal),
    .bus_err   (bus_err)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write,
                pc_write, reg_write, imm_src, alu_src_a,
                alu_src_b, alu_op, result_src, illegal,
                bus_err};

  typedef struct packed {
    bit          rdy;
    bit          z;
    logic [17:0] o;
  } step_t;

  step_t q[$];
  int total = 0;
  int bad = 0;

  // Pack one cycle's expected control word
  function automatic logic [17:0] v(
    bit req, bit wr, bit adr, bit ir, bit pc, bit rw,
    bit [1:0] imm, bit [1:0] sa, bit [1:0] sb,
    bit [1:0] op, bit [1:0] rs, bit ill, bit be);
    return {req, wr, adr, ir, pc, rw, imm, sa, sb, op,
            rs, ill, be};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic push(input bit rdy, input bit z,
                      input logic [17:0] o);
    step_t s;
    s.rdy = rdy;
    s.z = z;
    s.o = o;
    q.push_back(s);
  endtask

  // A memory access that is answered after w idle cycles,
  // or abandoned with a bus error once T cycles have gone
  task automatic mem_phase(input int w, input bit wr,
                           input bit adr, input bit fetch,
                           output bit err);
    int n;
    bit [1:0] sb;
    bit [1:0] rs;
    n = (w < T) ? w : T;
    sb = fetch ? 2'b10 : 2'b00;
    rs = fetch ? 2'b10 : 2'b00;
    for (int i = 0; i < n; i++)
      push(1'b0, rb(),
           v(1, wr, adr, 0, 0, 0, 0, 0, sb, 0, rs, 0, 0));
    if (w >= T) begin
      for (int i = 0; i < 4; i++)
        push(rb(), rb(),
             v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      err = 1'b1;
    end else begin
      push(1'b1, rb(),
           v(1, wr, adr, fetch, fetch, 0, 0, 0, sb, 0,
             rs, 0, 0));
      err = 1'b0;
    end
  endtask

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 illegal
  task automatic gen(input int kind, input bit [2:0] f3,
                     input int wf, input int wm,
                     input bit bz, output bit stuck);
    bit e;
    bit pc;
    stuck = 1'b0;
    case (kind)
      0: opcode = 7'b0000011;
      1: opcode = 7'b0100011;
      2: opcode = 7'b0110011;
      3: opcode = 7'b0010011;
      4: opcode = 7'b1100011;
      default: opcode = 7'b1111111;
    endcase
    funct3 = f3;
    funct7b5 = rb();
    mem_phase(wf, 0, 0, 1, e);
    if (e) begin
      stuck = 1'b1;
      return;
    end
    push(rb(), rb(),
         v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 0, 0,
           0, 0));
    case (kind)
      0, 1: begin
        push(rb(), rb(),
             v(0, 0, 0, 0, 0, 0, (kind == 0) ? 2'b00 : 2'b01,
               2'b10, 2'b01, 0, 0, 0, 0));
        mem_phase(wm, kind == 1, 1, 0, e);
        if (e) stuck = 1'b1;
        else if (kind == 0)
          push(rb(), rb(),
               v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 0, 0));
      end
      2, 3: begin
        push(rb(), rb(),
             v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10,
               (kind == 2) ? 2'b00 : 2'b01, 2'b10, 0, 0, 0));
        push(rb(), rb(),
             v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
      end
      4: begin
        pc = (f3 == 3'b000) ? bz :
             (f3 == 3'b001) ? !bz : 1'b0;
        push(rb(), bz,
             v(0, 0, 0, 0, pc, 0, 0, 2'b10, 2'b00, 2'b01,
               2'b00, 0, 0));
      end
      default: begin
        for (int i = 0; i < 4; i++)
          push(rb(), rb(),
               v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        stuck = 1'b1;
      end
    endcase
  endtask

  // Drive the queued timeline and compare every cycle
  task automatic play(input string nm);
    step_t s;
    int i;
    i = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.rdy;
      zero = s.z;
      @(negedge clk);
      total++;
      if (obs !== s.o) begin
        bad++;
        $display("FAIL %s[%0d] got=%h want=%h",
                 nm, i, obs, s.o);
      end
      @(posedge clk);
      #1;
      i++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = rb();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [17:0] fv;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs !== 18'h0) begin
        bad++;
        $display("FAIL rst_hold got=%h want=0", obs);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    fv = v(1, 0, 0, 1, 1, 0, 0, 0, 2'b10, 0, 2'b10, 0, 0);
    total++;
    if (obs !== fv) begin
      bad++;
      $display("FAIL rst_fetch got=%h want=%h", obs, fv);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 18'h0) begin
      bad++;
      $display("FAIL rst_mid got=%h want=0", obs);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    bit s;
    gen(0, 3'b010, 0, 0, 0, s);
    play("lw0");
    for (int i = 0; i < 4; i++) begin
      gen(0, 3'($urandom), $urandom_range(0, 2),
          $urandom_range(0, 2), 0, s);
      play("lw_rand");
    end
  endtask

  task automatic test_sw_wait();
    bit s;
    gen(1, 3'b010, 0, 3, 0, s);
    play("sw_wait3");
  endtask

  task automatic test_alu();
    bit s;
    for (int i = 0; i < 6; i++) begin
      gen(2 + (i % 2), 3'($urandom), $urandom_range(0, 2),
          0, 0, s);
      play("alu");
    end
  endtask

  task automatic test_branch();
    bit s;
    gen(4, 3'b000, 0, 0, 1, s);
    play("beq_z1");
    gen(4, 3'b001, 0, 0, 1, s);
    play("bne_z1");
    gen(4, 3'b100, 0, 0, 1, s);
    play("br_f3_100");
    for (int i = 0; i < 6; i++) begin
      gen(4, 3'($urandom_range(0, 2)), 0, 0, rb(), s);
      play("br_rand");
    end
  endtask

  task automatic test_illegal();
    bit s;
    gen(5, 3'b000, 0, 0, 0, s);
    play("illegal");
    do_reset();
    gen(2, 3'b000, 0, 0, 0, s);
    play("after_illegal");
  endtask

  task automatic test_timeout();
    bit s;
    gen(2, 3'b000, T, 0, 0, s);
    play("to_fetch");
    do_reset();
    gen(2, 3'b000, T - 1, 0, 0, s);
    play("to_fetch_edge");
    gen(0, 3'b010, 0, T, 0, s);
    play("to_memrd");
    do_reset();
    gen(1, 3'b010, 0, T - 1, 0, s);
    play("to_memwr_edge");
    gen(1, 3'b010, 0, T + 2, 0, s);
    play("to_memwr");
    do_reset();
  endtask

  task automatic test_back_to_back();
    bit s;
    int k;
    int wf;
    int wm;
    for (int i = 0; i < 40; i++) begin
      k = ($urandom_range(0, 19) == 0) ? 5
                                       : $urandom_range(0, 4);
      wf = ($urandom_range(0, 15) == 0) ? T
                                        : $urandom_range(0, 2);
      wm = ($urandom_range(0, 15) == 0) ? T
                                        : $urandom_range(0, 3);
      gen(k, 3'($urandom), wf, wm, rb(), s);
      play("b2b");
      if (s) do_reset();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = '0;
    funct3 = '0;
    funct7b5 = 1'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    #1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu();
    test_branch();
    test_illegal();
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
